// File: rtl/audio_sd_dac_if.sv
// Sample/enable inputs and bitstream/status outputs of the delta-sigma audio DAC.
interface audio_sd_dac_if #(
   parameter int unsigned SAMPLE_BITS = 16
);
   logic                   sample_ce;
   logic [SAMPLE_BITS-1:0] sample;
   logic                   enable;
   logic                   dac_out;
   logic                   muted;
   logic                   ramp_busy;

   modport master (
      output sample_ce, sample, enable,
      input  dac_out, muted, ramp_busy
   );

   modport slave (
      input  sample_ce, sample, enable,
      output dac_out, muted, ramp_busy
   );
endinterface

// File: rtl/audio_sd_dac.sv
// First-order delta-sigma audio DAC with a pop-free gain ramp between mute and full volume.
// Held sample is scaled by a 0..256 gain, then fed to a carry-out bitstream modulator.
module audio_sd_dac #(
   parameter int unsigned SAMPLE_BITS = 16,
   parameter int unsigned RAMP_DIV    = 4096
) (
   input  logic          clock,
   input  logic          reset_n,
   audio_sd_dac_if.slave bus
);
   localparam int unsigned GAIN_BITS = 9;
   localparam int unsigned PRE_BITS  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
   localparam int unsigned PROD_BITS = SAMPLE_BITS + GAIN_BITS;
   localparam int unsigned ACC_BITS  = SAMPLE_BITS + 1;
   localparam logic [GAIN_BITS-1:0] GAIN_FULL = GAIN_BITS'(256);
   localparam logic [GAIN_BITS-1:0] GAIN_TOP1 = GAIN_BITS'(255);
   localparam logic [GAIN_BITS-1:0] GAIN_ONE  = GAIN_BITS'(1);
   localparam logic [PRE_BITS-1:0]  PRE_LAST  = PRE_BITS'(RAMP_DIV - 1);

   typedef enum logic [1:0] {
      MUTE      = 2'd0,
      RAMP_UP   = 2'd1,
      RUN       = 2'd2,
      RAMP_DOWN = 2'd3
   } state_t;

   state_t                 state;
   logic [GAIN_BITS-1:0]   gain;
   logic [PRE_BITS-1:0]    prescaler;
   logic [SAMPLE_BITS-1:0] hold;
   logic [SAMPLE_BITS-1:0] eff;
   logic [ACC_BITS-1:0]    acc;
   logic                   dac_q;
   logic                   tick;
   logic [PROD_BITS-1:0]   product;

   assign tick    = (prescaler == PRE_LAST);
   assign product = PROD_BITS'(hold) * PROD_BITS'(gain);

   // Gain ramp controller: a direction change wins over a coincident gain step.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= MUTE;
         gain      <= '0;
         prescaler <= '0;
      end else begin
         case (state)
            MUTE: begin
               gain      <= '0;
               prescaler <= '0;
               if (bus.enable) state <= RAMP_UP;
            end
            RAMP_UP: begin
               prescaler <= tick ? '0 : prescaler + PRE_BITS'(1);
               if (!bus.enable) begin
                  state <= RAMP_DOWN;
               end else if (tick) begin
                  if (gain != GAIN_FULL) gain <= gain + GAIN_ONE;
                  if (gain >= GAIN_TOP1) state <= RUN;
               end
            end
            RUN: begin
               gain      <= GAIN_FULL;
               prescaler <= '0;
               if (!bus.enable) state <= RAMP_DOWN;
            end
            RAMP_DOWN: begin
               prescaler <= tick ? '0 : prescaler + PRE_BITS'(1);
               if (bus.enable) begin
                  state <= RAMP_UP;
               end else if (tick) begin
                  if (gain != '0) gain <= gain - GAIN_ONE;
                  if (gain <= GAIN_ONE) state <= MUTE;
               end
            end
            default: state <= MUTE;
         endcase
      end
   end

   // Sample hold, gain scaling and modulator pipeline.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         hold  <= '0;
         eff   <= '0;
         acc   <= '0;
         dac_q <= 1'b0;
      end else begin
         if (bus.sample_ce) hold <= bus.sample;
         eff   <= SAMPLE_BITS'(product >> 8);
         acc   <= {1'b0, acc[SAMPLE_BITS-1:0]} + {1'b0, eff};
         dac_q <= acc[SAMPLE_BITS];
      end
   end

   assign bus.dac_out   = dac_q;
   assign bus.muted     = (state == MUTE);
   assign bus.ramp_busy = (state == RAMP_UP) || (state == RAMP_DOWN);
endmodule

// File: tb/tb_audio_sd_dac.sv
// Scoreboard bench for audio_sd_dac with RAMP_DIV=4: reset, ramps, gain math, density, hold, reversal.
module tb_audio_sd_dac;
   localparam int unsigned SB  = 16;
   localparam int unsigned DIV = 4;
   localparam int unsigned WIN = 4096;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;
   int   exp_q[$];

   audio_sd_dac_if #(.SAMPLE_BITS(SB)) bus ();

   audio_sd_dac #(.SAMPLE_BITS(SB), .RAMP_DIV(DIV)) dut (
      .clock   (clk),
      .reset_n (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic do_reset();
      rst_n         = 1'b0;
      bus.enable    = 1'b0;
      bus.sample_ce = 1'b0;
      bus.sample    = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic count_ones(input int n, output int ones);
      ones = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (bus.dac_out === 1'b1) ones++;
      end
   endtask

   task automatic reach_run();
      bus.enable = 1'b1;
      for (int i = 0; i < 1200 && !(bus.muted === 1'b0 && bus.ramp_busy === 1'b0); i++)
         @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n         = 1'b0;
      bus.enable    = 1'b1;
      bus.sample    = 16'hFFFF;
      bus.sample_ce = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (bus.dac_out !== 1'b0) begin failures++; $display("FAIL reset_dac_out got=%b exp=0", bus.dac_out); end
      checks++;
      if (bus.muted !== 1'b1) begin failures++; $display("FAIL reset_muted got=%b exp=1", bus.muted); end
      checks++;
      if (bus.ramp_busy !== 1'b0) begin failures++; $display("FAIL reset_ramp_busy got=%b exp=0", bus.ramp_busy); end
      rst_n = 1'b1;
      repeat (300) @(negedge clk);
      checks++;
      if (bus.ramp_busy !== 1'b1) begin failures++; $display("FAIL midramp_busy got=%b exp=1", bus.ramp_busy); end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (bus.muted !== 1'b1 || bus.ramp_busy !== 1'b0 || bus.dac_out !== 1'b0)
         begin failures++; $display("FAIL async_reset got=%b%b%b exp=100", bus.muted, bus.ramp_busy, bus.dac_out); end
      checks++;
      if (dut.gain !== 9'd0) begin failures++; $display("FAIL async_reset_gain got=%0d exp=0", dut.gain); end
      do_reset();
   endtask

   task automatic test_gain_arith();
      do_reset();
      bus.sample    = 16'hFFFF;
      bus.sample_ce = 1'b1;
      bus.enable    = 1'b1;
      exp_q.push_back(32'h7FFF);
      for (int i = 0; i < 1200 && dut.gain !== 9'd128; i++) @(negedge clk);
      checks++;
      if (dut.gain !== 9'd128) begin failures++; $display("FAIL gain_reach128 got=%0d exp=128", dut.gain); end
      @(negedge clk);
      checks++;
      begin
         int e;
         e = exp_q.pop_front();
         if (int'(dut.eff) != e) begin failures++; $display("FAIL eff_gain128 got=%h exp=%h", dut.eff, e); end
      end
   endtask

   task automatic test_ramp_up();
      int cyc;
      do_reset();
      bus.enable = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.ramp_busy !== 1'b1) begin failures++; $display("FAIL rampup_busy got=%b exp=1", bus.ramp_busy); end
      cyc = 0;
      while (bus.ramp_busy === 1'b1 && cyc < 2000) begin
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (cyc < 1023 || cyc > 1025) begin failures++; $display("FAIL rampup_time got=%0d exp=1024", cyc); end
      checks++;
      if (bus.muted !== 1'b0) begin failures++; $display("FAIL run_muted got=%b exp=0", bus.muted); end
      checks++;
      if (dut.gain !== 9'd256) begin failures++; $display("FAIL run_gain got=%0d exp=256", dut.gain); end
   endtask

   task automatic test_density();
      logic [15:0] pats [4];
      int          expd [4];
      int          ones;
      int          e;
      pats[0] = 16'h4000; expd[0] = 1024;
      pats[1] = 16'h0000; expd[1] = 0;
      pats[2] = 16'h8000; expd[2] = 2048;
      pats[3] = 16'hFFFF; expd[3] = 4095;
      for (int p = 0; p < 4; p++) begin
         bus.sample    = pats[p];
         bus.sample_ce = 1'b1;
         exp_q.push_back(expd[p]);
         repeat (5) @(negedge clk);
         count_ones(WIN, ones);
         e = exp_q.pop_front();
         checks++;
         if (p == 3) begin
            // Window of 4096 with 0xFFFF: one zero may or may not fall inside, depending on phase.
            if (ones < e || ones > e + 1)
               begin failures++; $display("FAIL density_%h got=%0d exp=%0d..%0d", pats[p], ones, e, e + 1); end
         end else if (ones != e) begin
            failures++; $display("FAIL density_%h got=%0d exp=%0d", pats[p], ones, e);
         end
      end
   endtask

   task automatic test_hold();
      int  ones;
      int  e;
      bit  early_one;
      bit  saw_one;
      bus.sample    = 16'h0000;
      bus.sample_ce = 1'b1;
      repeat (6) @(negedge clk);
      bus.sample = 16'h8000;
      exp_q.push_back(2048);
      @(negedge clk);
      bus.sample_ce = 1'b0;
      bus.sample    = 16'h1000;
      early_one = (bus.dac_out === 1'b1);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         if (bus.dac_out === 1'b1) early_one = 1'b1;
      end
      checks++;
      if (early_one) begin failures++; $display("FAIL hold_latency got=early_one exp=zero_until_N+3"); end
      saw_one = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         if (bus.dac_out === 1'b1) saw_one = 1'b1;
      end
      checks++;
      if (!saw_one) begin failures++; $display("FAIL hold_first_one got=0 exp=1_by_N+4"); end
      checks++;
      if (dut.hold !== 16'h8000) begin failures++; $display("FAIL hold_value got=%h exp=8000", dut.hold); end
      count_ones(WIN, ones);
      e = exp_q.pop_front();
      checks++;
      if (ones != e) begin failures++; $display("FAIL hold_density got=%0d exp=%0d", ones, e); end
   endtask

   task automatic test_reversal();
      int  t99;
      int  tmute;
      int  prev;
      int  cur;
      bit  jump;
      do_reset();
      bus.sample    = 16'h8000;
      bus.sample_ce = 1'b1;
      bus.enable    = 1'b1;
      for (int i = 0; i < 1200 && dut.gain !== 9'd100; i++) @(negedge clk);
      checks++;
      if (dut.gain !== 9'd100) begin failures++; $display("FAIL rev_reach100 got=%0d exp=100", dut.gain); end
      bus.enable = 1'b0;
      prev  = int'(dut.gain);
      t99   = -1;
      tmute = -1;
      jump  = 1'b0;
      for (int i = 1; i <= 1000 && tmute < 0; i++) begin
         @(negedge clk);
         cur = int'(dut.gain);
         if (cur > prev || prev - cur > 1) jump = 1'b1;
         if (t99 < 0 && cur == 99) t99 = i;
         if (bus.muted === 1'b1) tmute = i;
         if (i == 1) begin
            checks++;
            if (bus.ramp_busy !== 1'b1 || cur != 100)
               begin failures++; $display("FAIL rev_first got=busy%b_gain%0d exp=busy1_gain100", bus.ramp_busy, cur); end
         end
         prev = cur;
      end
      checks++;
      if (t99 < 1 || t99 > 4) begin failures++; $display("FAIL rev_step99 got=%0d exp=1..4", t99); end
      checks++;
      if (tmute < 396 || tmute > 404) begin failures++; $display("FAIL rev_mute_time got=%0d exp=400", tmute); end
      checks++;
      if (jump) begin failures++; $display("FAIL rev_gain_jump got=1 exp=0"); end
      checks++;
      if (dut.gain !== 9'd0 || bus.ramp_busy !== 1'b0)
         begin failures++; $display("FAIL rev_final got=gain%0d_busy%b exp=gain0_busy0", dut.gain, bus.ramp_busy); end
   endtask

   initial begin
      checks        = 0;
      failures      = 0;
      rst_n         = 1'b0;
      bus.enable    = 1'b0;
      bus.sample_ce = 1'b0;
      bus.sample    = '0;
      test_reset();
      test_gain_arith();
      test_ramp_up();
      test_density();
      test_hold();
      test_reversal();
      checks++;
      if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size()); end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
